// File: rtl/led_blink_seq_pkg.sv
// led_blink_seq_pkg: shared definitions for the counted LED blink sequencer.
//   state_e   - FSM state encoding (idle / lit phase / dark phase)
//   calc_div  - clock cycles per timing tick
//   presc_w   - prescaler counter width for a given divider
package led_blink_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Never narrower than one bit, so a degenerate divider still elaborates.
    function automatic int unsigned presc_w(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler producing one tick every DIV clocks.
//   clk   in  system clock
//   rstn  in  synchronous reset, active-low
//   clr   in  restart the count at zero on the next edge
//   tick  out high during the last cycle of each DIV-cycle period
module led_tick_gen
    import led_blink_seq_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = presc_w(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            presc_q <= '0;
        end else if (presc_q == LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign tick = (presc_q == LAST);

endmodule

// File: rtl/led_blink_seq.sv
// led_blink_seq: blinks the LED a requested number of times.
//   clk            in  system clock
//   rstn           in  synchronous reset, active-low
//   req_valid      in  request present
//   req_ready      out block can accept a request (idle)
//   req_count      in  number of blinks (0 = complete immediately, no blink)
//   req_on_ticks   in  lit ticks per blink (0 treated as 1)
//   req_off_ticks  in  dark ticks after each blink (0 treated as 1)
//   led            out LED drive, LED_ON when lit
//   busy           out sequence in progress
//   done           out one-cycle pulse when a sequence completes
module led_blink_seq
    import led_blink_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 25000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DUR_W   = 16,
    parameter logic        LED_ON  = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [DUR_W-1:0] req_on_ticks,
    input  logic [DUR_W-1:0] req_off_ticks,
    output logic             led,
    output logic             busy,
    output logic             done
);

    // DIV must be an integer >= 2.
    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

    state_e           state_q;
    logic             led_q;
    logic             done_q;
    logic [CNT_W-1:0] remaining_q;
    logic [DUR_W-1:0] dur_q;
    logic [DUR_W-1:0] on_q;
    logic [DUR_W-1:0] off_q;

    logic             tick;
    logic             accept;
    logic             on_last;
    logic             off_last;
    logic [DUR_W-1:0] on_eff;
    logic [DUR_W-1:0] off_eff;

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign accept    = req_valid && req_ready;

    assign on_eff  = (req_on_ticks  == '0) ? DUR_W'(1) : req_on_ticks;
    assign off_eff = (req_off_ticks == '0) ? DUR_W'(1) : req_off_ticks;

    // Final tick of the current phase; latched durations are never zero.
    assign on_last  = tick && (state_q == StOn)  && (dur_q == on_q  - DUR_W'(1));
    assign off_last = tick && (state_q == StOff) && (dur_q == off_q - DUR_W'(1));

    // Realigning the prescaler on accept makes each phase exactly N*DIV cycles.
    led_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept || on_last || off_last),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            led_q       <= ~LED_ON;
            done_q      <= 1'b0;
            remaining_q <= '0;
            dur_q       <= '0;
            on_q        <= '0;
            off_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        on_q        <= on_eff;
                        off_q       <= off_eff;
                        remaining_q <= req_count;
                        dur_q       <= '0;
                        if (req_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StOn;
                            led_q   <= LED_ON;
                        end
                    end
                end
                StOn: begin
                    if (on_last) begin
                        state_q <= StOff;
                        led_q   <= ~LED_ON;
                        dur_q   <= '0;
                    end else if (tick) begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
                end
                StOff: begin
                    if (off_last) begin
                        dur_q <= '0;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q     <= StIdle;
                            done_q      <= 1'b1;
                            remaining_q <= '0;
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(1);
                            state_q     <= StOn;
                            led_q       <= LED_ON;
                        end
                    end else if (tick) begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    led_q   <= ~LED_ON;
                end
            endcase
        end
    end

    assign led  = led_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_blink_seq.sv
// tb_led_blink_seq: table-driven bench with a done-time scoreboard for led_blink_seq.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_led_blink_seq;

    localparam int DIV = 10;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_count;
    logic [15:0] req_on_ticks;
    logic [15:0] req_off_ticks;
    logic        led;
    logic        busy;
    logic        done;

    led_blink_seq #(
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .CNT_W   (8),
        .DUR_W   (16),
        .LED_ON  (1'b1)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_count     (req_count),
        .req_on_ticks  (req_on_ticks),
        .req_off_ticks (req_off_ticks),
        .led           (led),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int count;
        int on;
        int off;
        int exp_rises;
        int exp_high;
        int exp_busy;
        int exp_p20;
    } vec_t;

    vec_t vecs[6];

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int acc_cnt = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    int high_cnt = 0;
    int busy_cnt = 0;
    int rdy_low_cnt = 0;
    int p20_cnt = 0;
    int b2b_cnt = 0;
    int prev_rise = -1;
    logic led_prev = 1'b0;

    function automatic int model_lat(input int c, input int on, input int off);
        int on_e;
        int off_e;
        on_e  = (on == 0) ? 1 : on;
        off_e = (off == 0) ? 1 : off;
        if (c == 0) return 0;
        return c * (on_e + off_e) * DIV;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Falling-edge observer: scoreboard for done, plus cumulative activity counters.
    task automatic monitor();
        int e;
        if (!rstn) begin
            exp_q.delete();
            prev_rise = -1;
        end else begin
            if (done === 1'b1) begin
                done_cnt++;
                if (req_valid && req_ready) b2b_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_sb: unexpected done at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e != cyc) begin
                        errors++;
                        $display("FAIL done_sb: done at cycle %0d expected %0d", cyc, e);
                    end
                end
                prev_rise = -1;
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                acc_cnt++;
                exp_q.push_back(cyc + 1 + model_lat(int'(req_count), int'(req_on_ticks),
                                                    int'(req_off_ticks)));
            end
            if (led === 1'b1 && led_prev !== 1'b1) begin
                rise_cnt++;
                if (prev_rise >= 0 && cyc - prev_rise == 20) p20_cnt++;
                prev_rise = cyc;
            end
            if (led === 1'b1) high_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (req_ready === 1'b0) rdy_low_cnt++;
        end
        led_prev = led;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int r0, h0, b0, l0, p0, budget;
        r0 = rise_cnt; h0 = high_cnt; b0 = busy_cnt; l0 = rdy_low_cnt; p0 = p20_cnt;
        budget = 0;
        while (req_ready !== 1'b1 && budget < 2000) begin step(); budget++; end
        req_valid     = 1'b1;
        req_count     = 8'(v.count);
        req_on_ticks  = 16'(v.on);
        req_off_ticks = 16'(v.off);
        step();
        // Inputs changed after accept must not affect the running sequence.
        req_valid     = 1'b0;
        req_count     = 8'd9;
        req_on_ticks  = 16'd7;
        req_off_ticks = 16'd7;
        budget = 0;
        while (exp_q.size() != 0 && budget < 5000) begin step(); budget++; end
        chk($sformatf("v%0d_done_in_time", idx), int'(budget < 5000), 1);
        repeat (3) step();
        chk($sformatf("v%0d_rises", idx), rise_cnt - r0, v.exp_rises);
        chk($sformatf("v%0d_high_cycles", idx), high_cnt - h0, v.exp_high);
        chk($sformatf("v%0d_busy_cycles", idx), busy_cnt - b0, v.exp_busy);
        chk($sformatf("v%0d_ready_low_cycles", idx), rdy_low_cnt - l0, v.exp_busy);
        chk($sformatf("v%0d_period20", idx), p20_cnt - p0, v.exp_p20);
    endtask

    initial begin
        int a0, d0, b0, budget;

        //            count on off rises high busy p20
        vecs[0] = '{1, 2, 3, 1, 20, 50, 0};
        vecs[1] = '{3, 1, 1, 3, 30, 60, 2};
        vecs[2] = '{0, 5, 5, 0, 0, 0, 0};
        vecs[3] = '{1, 0, 0, 1, 10, 20, 0};
        vecs[4] = '{2, 3, 1, 2, 60, 80, 0};
        vecs[5] = '{1, 1, 4, 1, 10, 50, 0};

        rstn          = 1'b0;
        req_valid     = 1'b0;
        req_count     = '0;
        req_on_ticks  = '0;
        req_off_ticks = '0;

        repeat (5) step();
        rstn = 1'b1;
        step();
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(req_ready), 1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back: valid held high, second accept coincides with first done.
        a0 = acc_cnt; d0 = done_cnt; b0 = b2b_cnt;
        req_valid     = 1'b1;
        req_count     = 8'd2;
        req_on_ticks  = 16'd1;
        req_off_ticks = 16'd1;
        budget = 0;
        while (acc_cnt - a0 < 2 && budget < 500) begin step(); budget++; end
        req_valid = 1'b0;
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_same_cycle", b2b_cnt - b0, 1);
        chk("b2b_first_done", done_cnt - d0, 1);

        // Abort the second sequence during its lit phase.
        repeat (3) step();
        chk("abort_led_lit", int'(led), 1);
        rstn = 1'b0;
        step();
        chk("abort_led", int'(led), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(req_ready), 1);
        chk("abort_done", int'(done), 0);
        rstn = 1'b1;
        repeat (60) step();
        chk("abort_no_done", done_cnt - d0, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
